// File: rtl/kmap_lut_seq.sv
// Runtime-reloadable IN_W-input Boolean function evaluator with a serial table
// load port and a valid/ready result stream. Optional macro: KMAP_LUT_ONES_CNT_EN.
module kmap_lut_seq #(
    parameter int           IN_W       = 4,
    parameter logic [255:0] INIT_TABLE = 256'hD073
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            f
`ifdef KMAP_LUT_ONES_CNT_EN
    ,
    output logic [15:0]     ones_cnt
`endif
);

    localparam int TW = 1 << IN_W;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   table_r;
    logic [TW-1:0]   shadow_r;
    logic [TW-1:0]   shadow_fill_s;
    logic [IN_W-1:0] cnt_r;
    logic            last_bit_s;
    logic            cfg_busy_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            out_valid_r;
    logic            f_r;
    logic            cfg_done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a restart request outranks a final bit in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        last_bit_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (cfg_start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                last_bit_s = cfg_valid && !cfg_start && (cnt_r == IN_W'(TW - 1));
                if (cfg_start) begin
                    state_nxt_s = ST_LOAD;
                end else if (last_bit_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Output/handshake decode derived from registered state.
    always_comb begin
        cfg_busy_s = (state_r == ST_LOAD);
        in_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Shadow with the incoming bit merged in, so the final bit commits atomically.
    always_comb begin
        shadow_fill_s        = shadow_r;
        shadow_fill_s[cnt_r] = cfg_bit;
    end

    // Table load datapath.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            table_r    <= INIT_TABLE[TW-1:0];
            shadow_r   <= {TW{1'b0}};
            cnt_r      <= {IN_W{1'b0}};
            cfg_done_r <= 1'b0;
        end else begin
            cfg_done_r <= last_bit_s;
            if (cfg_start) begin
                shadow_r <= {TW{1'b0}};
                cnt_r    <= {IN_W{1'b0}};
            end else if ((state_r == ST_LOAD) && cfg_valid) begin
                shadow_r <= shadow_fill_s;
                cnt_r    <= cnt_r + IN_W'(1);
                if (last_bit_s) begin
                    table_r <= shadow_fill_s;
                end else begin
                    table_r <= table_r;
                end
            end else begin
                shadow_r <= shadow_r;
                cnt_r    <= cnt_r;
            end
        end
    end

    // Result register; a pending result keeps the value from the table it saw.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            f_r         <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            f_r         <= table_r[x];
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef KMAP_LUT_ONES_CNT_EN
    logic [15:0] ones_cnt_r;

    // Saturating count of delivered ones, cleared when a new table commits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ones_cnt_r <= 16'h0000;
        end else if (cfg_done_r) begin
            ones_cnt_r <= 16'h0000;
        end else if (out_valid_r && out_ready && f_r && (ones_cnt_r != 16'hFFFF)) begin
            ones_cnt_r <= ones_cnt_r + 16'h0001;
        end else begin
            ones_cnt_r <= ones_cnt_r;
        end
    end

    assign ones_cnt = ones_cnt_r;
`endif

    assign cfg_busy  = cfg_busy_s;
    assign cfg_done  = cfg_done_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign f         = f_r;

endmodule

// File: tb/tb_kmap_lut_seq.sv
// Self-checking bench for kmap_lut_seq: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_kmap_lut_seq;

    localparam int          TW   = 16;
    localparam logic [15:0] INIT = 16'hD073;

    logic       clk = 1'b0;
    logic       resetn, cfg_start, cfg_valid, cfg_bit;
    logic       cfg_busy, cfg_done, in_valid, in_ready;
    logic [3:0] x;
    logic       out_valid, out_ready, f;
`ifdef KMAP_LUT_ONES_CNT_EN
    logic [15:0] ones_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit          m_known = 1'b0;
    logic [15:0] m_table;
    bit          m_loading;
    int          m_cnt;
    logic [15:0] m_shadow;
    bit          m_ov;
    logic        m_f;
    bit          m_done;
    int          m_ones;

    logic [15:0] cap;
    int          n_cap;
    int          n_done_seen;

    kmap_lut_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f)
`ifdef KMAP_LUT_ONES_CNT_EN
        ,
        .ones_cnt  (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model, advance the model one clock, wait to next negedge.
    task automatic tick();
        bit nd;
        bit rdy;
        bit acc;
        #1;
        if (m_known) begin
            chk("cfg_busy", cfg_busy, m_loading);
            chk("cfg_done", cfg_done, m_done);
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, !m_loading && (!m_ov || out_ready));
            if (m_ov) chk("f", f, m_f);
`ifdef KMAP_LUT_ONES_CNT_EN
            chk("ones_cnt", ones_cnt, m_ones);
`endif
        end
        if (out_valid === 1'b1 && out_ready) begin
            cap = {f, cap[15:1]};
            n_cap++;
        end
        if (cfg_done === 1'b1) n_done_seen++;
        if (!resetn) begin
            m_known   = 1'b1;
            m_table   = INIT;
            m_loading = 1'b0;
            m_cnt     = 0;
            m_shadow  = 16'h0000;
            m_ov      = 1'b0;
            m_f       = 1'b0;
            m_done    = 1'b0;
            m_ones    = 0;
        end else begin
            rdy = !m_loading && (!m_ov || out_ready);
            acc = in_valid && rdy;
            if (m_done) m_ones = 0;
            else if (m_ov && out_ready && m_f && m_ones < 65535) m_ones++;
            if (acc) begin
                m_f  = m_table[x];
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            nd = 1'b0;
            if (cfg_start) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_shadow  = 16'h0000;
            end else if (m_loading && cfg_valid) begin
                m_shadow[m_cnt] = cfg_bit;
                m_cnt++;
                if (m_cnt == TW) begin
                    m_table   = m_shadow;
                    m_loading = 1'b0;
                    nd        = 1'b1;
                end
            end
            m_done = nd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        x         = 4'h0;
        out_ready = 1'b1;
    endtask

    task automatic stream_all();
        cap   = 16'h0000;
        n_cap = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic lookup(input int v, input logic e, input string name);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        x         = 4'(v);
        tick();
        in_valid = 1'b0;
        #1;
        chk(name, f, e);
        chk({name, "_ov"}, out_valid, 1'b1);
        tick();
    endtask

    // First cycle asserts cfg_start together with a cfg_valid that must be ignored.
    task automatic load(input logic [15:0] val, input bit gapped);
        n_done_seen = 0;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            cfg_valid = 1'b1;
            cfg_bit   = val[b];
            #1;
            chk("load_busy", cfg_busy, 1'b1);
            chk("load_in_ready", in_ready, 1'b0);
            tick();
            if (gapped) begin
                cfg_valid = 1'b0;
                tick();
            end
        end
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("done_pulses", n_done_seen, 1);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_cfg_busy", cfg_busy, 1'b0);
        chk("rst_cfg_done", cfg_done, 1'b0);

        // Full sweep of the reset table.
        stream_all();
        chk("sweep_init", cap, 16'hD073);
        chk("sweep_count", n_cap, 16);
`ifdef KMAP_LUT_ONES_CNT_EN
        chk("ones_after_sweep", ones_cnt, 16'd8);
`endif

        // Backpressure holds the x=4 result and blocks new input.
        in_valid = 1'b1;
        x        = 4'd4;
        tick();
        out_ready = 1'b0;
        x         = 4'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_f", f, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_next_f", f, 1'b0);
        tick();

        // Gapped reload with all zeros.
        load(16'h0000, 1'b1);
`ifdef KMAP_LUT_ONES_CNT_EN
        chk("ones_after_load", ones_cnt, 16'd0);
`endif
        stream_all();
        chk("sweep_zero", cap, 16'h0000);

        // Restart after 7 bits, then load 8001.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        load(16'h8001, 1'b0);
        lookup(0, 1'b1, "t8001_x0");
        lookup(15, 1'b1, "t8001_x15");
        lookup(7, 1'b0, "t8001_x7");

        // Reset in the middle of a load restores the initial table.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int b = 0; b < 9; b++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        resetn    = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("midrst_busy", cfg_busy, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        lookup(3, 1'b0, "midrst_x3");
        lookup(4, 1'b1, "midrst_x4");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            resetn    = ($urandom_range(0, 499) != 0);
            cfg_start = ($urandom_range(0, 59) == 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_bit   = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            x         = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        resetn = 1'b1;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
